fetch_unit: RTL

- Instruction fetch stage directly upstream of the decoder.
- Holds the PC and issues in-order word requests to instruction memory.
- Buffers returned words in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Accepts a redirect (branch/jump target) that squashes all younger fetches.

---
 rtl/fetch_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the decoder.
//
// Holds the PC, issues in-order word requests to instruction memory, buffers
// returned words in a small FIFO and presents them to the decoder with a
// valid/ready handshake. A redirect squashes every younger fetch: the FIFO is
// flushed and responses still in flight are counted down and dropped (DRAIN).
//
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   imem_req_valid/ready/addr        request channel to instruction memory
//   imem_resp_valid/data             in-order response channel, latency >= 1
//   redirect_valid/pc                branch/jump target, low two bits ignored
//   inst_valid/ready                 handshake to the decoder
//   instruction, inst_pc             FIFO head word and its PC (0 when empty)
//   perf_fetched                     decoder handshake count (FETCH_PERF_EN only)
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetched counter port.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]        CAP     = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, resp_pc;
  logic [CNT_W-1:0]      outstanding, outstanding_nxt;
  logic [CNT_W-1:0]      discard, discard_nxt;
  logic [CNT_W-1:0]      in_flight, squash_n;
  logic [CNT_W-1:0]      fifo_count;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_inst [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];

  logic                  fifo_empty;
  logic                  pop, push, req_fire, orphan;
  logic [CNT_W:0]        occupancy;
  logic [DATA_WIDTH-1:0] redirect_tgt;

  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign redirect_tgt = redirect_pc & ~DATA_WIDTH'(3);

  // Decoder side: FIFO head is the output, no register in between.
  assign fifo_empty  = (fifo_count == '0);
  assign inst_valid  = !fifo_empty && !redirect_valid;
  assign pop         = inst_valid && inst_ready;
  assign instruction = fifo_empty ? '0 : fifo_inst[rd_ptr];
  assign inst_pc     = fifo_empty ? '0 : fifo_pc[rd_ptr];

  // Slot accounting: outstanding requests plus buffered words never exceed
  // FIFO_DEPTH. A pop this cycle frees its slot in time for the new request,
  // which is what sustains one fetch per cycle with a depth of two.
  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count}
                   - {{CNT_W{1'b0}}, pop};

  assign imem_req_valid = !rst && (state == FETCH) && !redirect_valid
                          && (occupancy < CAP);
  assign imem_req_addr  = rst ? '0 : pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Only live (non-squashed) responses enter the FIFO.
  assign push   = imem_resp_valid && (state == FETCH) && !redirect_valid
                  && (outstanding != '0);
  assign orphan = imem_resp_valid
                  && (((state == FETCH) && (outstanding == '0))
                   || ((state == DRAIN) && (discard == '0)));

  always_comb begin
    state_nxt       = state;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    in_flight       = (state == FETCH) ? outstanding : discard;
    // A response landing in the redirect cycle retires one in-flight request.
    squash_n        = in_flight
                    - ((imem_resp_valid && (in_flight != '0)) ? CNT_ONE : '0);
    if (redirect_valid) begin
      outstanding_nxt = '0;
      discard_nxt     = squash_n;
      state_nxt       = (squash_n != '0) ? DRAIN : FETCH;
    end else if (state == FETCH) begin
      outstanding_nxt = outstanding + (req_fire ? CNT_ONE : '0)
                                    - (push     ? CNT_ONE : '0);
    end else begin
      if (imem_resp_valid && (discard != '0)) begin
        discard_nxt = discard - CNT_ONE;
      end
      if (discard_nxt == '0) begin
        state_nxt = FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      resp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc      <= redirect_tgt;
      resp_pc <= redirect_tgt;
    end else begin
      if (req_fire) pc      <= pc + PC_STEP;
      if (push)     resp_pc <= resp_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else if (redirect_valid) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      fifo_count <= fifo_count + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage carries no reset; fifo_count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
    end else if (pop) begin
      perf_fetched <= perf_fetched + 32'd1;
    end
  end
`endif

  // A response with nothing outstanding and nothing to discard is dropped in
  // hardware; in simulation it stops the run because the memory misbehaved.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!orphan)
        else $fatal(1, "fetch_unit: response with no outstanding request");
    end
  end

endmodule
